// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares one Avalon-MM style SDRAM controller command port between two masters
// (m0 = CPU data master, m1 = DMA/streaming master) on sys_clk.
//
//   * Round-robin arbitration; a command stalled by s_wait keeps the grant
//     (lock) until the controller accepts it.
//   * Each accepted read pushes the issuing master id into an in-order tag
//     FIFO; each s_rvalid pops the head and routes the beat to that master.
//   * Reads are held back while MAX_PEND reads are outstanding.
//   * err is a sticky flag for protocol violations (read+write together,
//     request dropped while locked, response with nothing outstanding).
//
// Ports
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   mN_addr/read/write/wdata/be   master N command (N = 0, 1)
//   mN_wait                   stall to master N
//   mN_rdata, mN_rvalid       read response to master N
//   s_addr/wdata/be/read/write    command to the controller
//   s_wait                    controller stall
//   s_rdata, s_rvalid         controller read response (in issue order)
//   pend_cnt                  outstanding reads (registered)
//   err                       sticky protocol error (registered)
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
    parameter int AW       = 24,
    parameter int DW       = 16,
    parameter int MAX_PEND = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic [AW-1:0]               m0_addr,
    input  logic                        m0_read,
    input  logic                        m0_write,
    input  logic [DW-1:0]               m0_wdata,
    input  logic [DW/8-1:0]             m0_be,
    output logic                        m0_wait,
    output logic [DW-1:0]               m0_rdata,
    output logic                        m0_rvalid,
    input  logic [AW-1:0]               m1_addr,
    input  logic                        m1_read,
    input  logic                        m1_write,
    input  logic [DW-1:0]               m1_wdata,
    input  logic [DW/8-1:0]             m1_be,
    output logic                        m1_wait,
    output logic [DW-1:0]               m1_rdata,
    output logic                        m1_rvalid,
    output logic [AW-1:0]               s_addr,
    output logic [DW-1:0]               s_wdata,
    output logic [DW/8-1:0]             s_be,
    output logic                        s_read,
    output logic                        s_write,
    input  logic                        s_wait,
    input  logic [DW-1:0]               s_rdata,
    input  logic                        s_rvalid,
    output logic [$clog2(MAX_PEND):0]   pend_cnt,
    output logic                        err
);

    localparam int PW = $clog2(MAX_PEND);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(MAX_PEND);

    // State
    logic                rr_q, rr_d;
    logic                lock_q, lock_d;
    logic                lock_id_q, lock_id_d;
    logic [MAX_PEND-1:0] tag_q, tag_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW:0]         cnt_q, cnt_d;
    logic                err_q, err_d;

    // Combinational helpers
    logic req0_s, req1_s;
    logic gnt_vld_s, gnt_id_s;
    logic g_rd_s, g_wr_s;
    logic full_s, blk_s, fwd_s, acc_s;
    logic push_s, pop_s, head_s;
    logic lock_req_s, illegal_s;

    assign req0_s = m0_read | m0_write;
    assign req1_s = m1_read | m1_write;

    // Grant selection: lock holder first, then lone requester, then round-robin
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_id_s  = 1'b0;
        if (lock_q) begin
            gnt_vld_s = 1'b1;
            gnt_id_s  = lock_id_q;
        end else if (req0_s && !req1_s) begin
            gnt_vld_s = 1'b1;
            gnt_id_s  = 1'b0;
        end else if (!req0_s && req1_s) begin
            gnt_vld_s = 1'b1;
            gnt_id_s  = 1'b1;
        end else if (req0_s && req1_s) begin
            gnt_vld_s = 1'b1;
            gnt_id_s  = ~rr_q;
        end else begin
            gnt_vld_s = 1'b0;
            gnt_id_s  = 1'b0;
        end
    end

    // read+write together is executed as a write
    assign g_rd_s = gnt_id_s ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
    assign g_wr_s = gnt_id_s ? m1_write : m0_write;

    assign full_s = (cnt_q == FULL_CNT);
    assign blk_s  = gnt_vld_s & g_rd_s & full_s;

    // Forwarding; with no grant gnt_id_s is 0 so fields come from m0
    assign s_addr  = gnt_id_s ? m1_addr  : m0_addr;
    assign s_wdata = gnt_id_s ? m1_wdata : m0_wdata;
    assign s_be    = gnt_id_s ? m1_be    : m0_be;
    assign s_read  = ~sys_rst & gnt_vld_s & g_rd_s & ~full_s;
    assign s_write = ~sys_rst & gnt_vld_s & g_wr_s;

    assign fwd_s = s_read | s_write;
    assign acc_s = fwd_s & ~s_wait;

    // Granted master follows the controller stall (or is held while reads are
    // blocked); the other master is stalled only when it actually requests.
    assign m0_wait = sys_rst ? 1'b1 :
                     (gnt_vld_s && !gnt_id_s) ? (blk_s | s_wait) : req0_s;
    assign m1_wait = sys_rst ? 1'b1 :
                     (gnt_vld_s &&  gnt_id_s) ? (blk_s | s_wait) : req1_s;

    // Response routing from the tag FIFO head
    assign push_s    = acc_s & s_read;
    assign pop_s     = ~sys_rst & s_rvalid & (cnt_q != {(PW+1){1'b0}});
    assign head_s    = tag_q[rd_ptr_q];
    assign m0_rvalid = pop_s & ~head_s;
    assign m1_rvalid = pop_s &  head_s;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;

    assign lock_req_s = lock_id_q ? req1_s : req0_s;
    assign illegal_s  = (m0_read & m0_write) | (m1_read & m1_write);

    // Next-state: arbitration history, lock, tag FIFO and error flag
    always_comb begin
        rr_d      = rr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        tag_d     = tag_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        if (acc_s) begin
            rr_d   = gnt_id_s;
            lock_d = 1'b0;
        end else if (fwd_s && s_wait) begin
            lock_d    = 1'b1;
            lock_id_d = gnt_id_s;
        end else if (lock_q && !lock_req_s) begin
            // lock holder withdrew its stalled command
            lock_d = 1'b0;
            err_d  = 1'b1;
        end else begin
            lock_d = lock_q;
        end

        if (illegal_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end

        if (s_rvalid && (cnt_q == {(PW+1){1'b0}})) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end

        if (push_s) begin
            tag_d[wr_ptr_q] = gnt_id_s;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rr_q      <= 1'b1;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            tag_q     <= {MAX_PEND{1'b0}};
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            cnt_q     <= {(PW+1){1'b0}};
            err_q     <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            tag_q     <= tag_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign pend_cnt = cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for sdram_port_arbiter.
// Inputs change 2 time units after each rising edge; outputs are checked 1 time
// unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int MAX_PEND = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [AW-1:0] m0_addr, m1_addr;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [1:0]    m0_be, m1_be;
    logic          m0_wait, m1_wait, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [1:0]    s_be;
    logic          s_read, s_write, s_wait, s_rvalid;
    logic [DW-1:0] s_rdata;
    logic [2:0]    pend_cnt;
    logic          err;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    always #5 sys_clk = ~sys_clk;

    sdram_port_arbiter #(.AW(AW), .DW(DW), .MAX_PEND(MAX_PEND)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_addr(m0_addr), .m0_read(m0_read), .m0_write(m0_write),
        .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_wait(m0_wait),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_addr(m1_addr), .m1_read(m1_read), .m1_write(m1_write),
        .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_wait(m1_wait),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
        .s_read(s_read), .s_write(s_write), .s_wait(s_wait),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .pend_cnt(pend_cnt), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        s_rvalid = 1'b0; s_wait = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        sys_rst = 1'b1;
        cyc();
        sys_rst = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1;
        m0_addr = 24'h0; m1_addr = 24'h0;
        m0_wdata = 16'h0; m1_wdata = 16'h0;
        m0_be = 2'b11; m1_be = 2'b11;
        s_rdata = 16'h0;
        idle();

        // ---- reset cycle: requests and responses masked
        #2;
        m0_read = 1'b1; s_rvalid = 1'b1;
        settle();
        chk("rst_s_read",    32'(s_read), 32'd0);
        chk("rst_m0_wait",   32'(m0_wait), 32'd1);
        chk("rst_m1_wait",   32'(m1_wait), 32'd1);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        cyc();
        sys_rst = 1'b0;
        idle();
        settle();
        chk("rst_pend", 32'(pend_cnt), 32'd0);
        chk("rst_err",  32'(err), 32'd0);

        // ---- m0 read alone, response 3 cycles later
        m0_read = 1'b1; m0_addr = 24'h123456;
        settle();
        chk("rd_s_read",  32'(s_read), 32'd1);
        chk("rd_s_addr",  32'(s_addr), 32'h123456);
        chk("rd_m0_wait", 32'(m0_wait), 32'd0);
        cyc();
        m0_read = 1'b0;
        settle();
        chk("rd_pend1", 32'(pend_cnt), 32'd1);
        cyc();
        cyc();
        s_rvalid = 1'b1; s_rdata = 16'hBEEF;
        settle();
        chk("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("rd_m0_rdata",  32'(m0_rdata), 32'hBEEF);
        chk("rd_m1_rvalid", 32'(m1_rvalid), 32'd0);
        cyc();
        s_rvalid = 1'b0;
        settle();
        chk("rd_pend0", 32'(pend_cnt), 32'd0);

        // ---- both masters writing continuously from reset: alternate m0,m1
        do_reset();
        m0_write = 1'b1; m0_addr = 24'h000AAA; m0_wdata = 16'hA0A0; m0_be = 2'b01;
        m1_write = 1'b1; m1_addr = 24'h000BBB; m1_wdata = 16'hB1B1; m1_be = 2'b10;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr_s_write", 32'(s_write), 32'd1);
            chk("rr_s_addr",  32'(s_addr), (i % 2 == 1) ? 32'h000BBB : 32'h000AAA);
            chk("rr_s_be",    32'(s_be), (i % 2 == 1) ? 32'd2 : 32'd1);
            chk("rr_m0_wait", 32'(m0_wait), (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_m1_wait", 32'(m1_wait), (i % 2 == 1) ? 32'd0 : 32'd1);
            cyc();
        end

        // ---- m1 stalled 5 cycles holds the grant against m0
        m0_write = 1'b0; s_wait = 1'b1;
        settle();
        chk("lk0_s_wdata", 32'(s_wdata), 32'hB1B1);
        chk("lk0_m1_wait", 32'(m1_wait), 32'd1);
        chk("lk0_m0_wait", 32'(m0_wait), 32'd0);
        cyc();
        m0_write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("lk_s_wdata", 32'(s_wdata), 32'hB1B1);
            chk("lk_m0_wait", 32'(m0_wait), 32'd1);
            chk("lk_m1_wait", 32'(m1_wait), 32'd1);
            cyc();
        end
        s_wait = 1'b0;
        settle();
        chk("lk_acc_wdata",  32'(s_wdata), 32'hB1B1);
        chk("lk_acc_m1wait", 32'(m1_wait), 32'd0);
        cyc();
        settle();
        chk("lk_next_wdata",  32'(s_wdata), 32'hA0A0);
        chk("lk_next_m0wait", 32'(m0_wait), 32'd0);
        chk("lk_next_m1wait", 32'(m1_wait), 32'd1);
        cyc();
        idle();
        settle();
        chk("lk_err", 32'(err), 32'd0);

        // ---- fill 4 reads, 5th held, responses routed in order
        for (int i = 0; i < 4; i++) begin
            m0_read = (i % 2 == 0); m1_read = (i % 2 == 1);
            m0_addr = 24'h000100 + 24'(i); m1_addr = 24'h000100 + 24'(i);
            settle();
            chk("fill_s_read", 32'(s_read), 32'd1);
            cyc();
        end
        m1_read = 1'b0; m0_read = 1'b1; m0_addr = 24'h000200;
        settle();
        chk("full_pend",    32'(pend_cnt), 32'd4);
        chk("full_s_read",  32'(s_read), 32'd0);
        chk("full_m0_wait", 32'(m0_wait), 32'd1);
        cyc();
        s_rvalid = 1'b1; s_rdata = 16'h1111;
        settle();
        chk("r1_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("r1_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("r1_m0_rdata",  32'(m0_rdata), 32'h1111);
        chk("r1_s_read",    32'(s_read), 32'd0);
        cyc();
        s_rdata = 16'h2222;
        settle();
        chk("r2_m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("r2_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("r2_m1_rdata",  32'(m1_rdata), 32'h2222);
        chk("r2_s_read",    32'(s_read), 32'd1);
        chk("r2_s_addr",    32'(s_addr), 32'h000200);
        chk("r2_m0_wait",   32'(m0_wait), 32'd0);
        cyc();
        m0_read = 1'b0; s_rdata = 16'h3333;
        settle();
        chk("r3_pend",      32'(pend_cnt), 32'd3);
        chk("r3_m0_rvalid", 32'(m0_rvalid), 32'd1);
        cyc();
        s_rdata = 16'h4444;
        settle();
        chk("r4_m1_rvalid", 32'(m1_rvalid), 32'd1);
        cyc();
        s_rdata = 16'h5555;
        settle();
        chk("r5_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("r5_m1_rvalid", 32'(m1_rvalid), 32'd0);
        cyc();
        s_rvalid = 1'b0;
        settle();
        chk("r5_pend", 32'(pend_cnt), 32'd0);

        // ---- simultaneous push/pop at pend_cnt=2
        m1_read = 1'b1;
        cyc();
        m1_read = 1'b0; m0_read = 1'b1;
        cyc();
        m0_read = 1'b0; m1_read = 1'b1; s_rvalid = 1'b1; s_rdata = 16'h6666;
        settle();
        chk("pp_pend_before", 32'(pend_cnt), 32'd2);
        chk("pp_m1_rvalid",   32'(m1_rvalid), 32'd1);
        chk("pp_m0_rvalid",   32'(m0_rvalid), 32'd0);
        chk("pp_s_read",      32'(s_read), 32'd1);
        cyc();
        m1_read = 1'b0; s_rdata = 16'h7777;
        settle();
        chk("pp_pend_after", 32'(pend_cnt), 32'd2);
        chk("pp_o1_m0",      32'(m0_rvalid), 32'd1);
        cyc();
        s_rdata = 16'h8888;
        settle();
        chk("pp_o2_m1", 32'(m1_rvalid), 32'd1);
        chk("pp_o2_m0", 32'(m0_rvalid), 32'd0);
        cyc();
        s_rvalid = 1'b0;
        settle();
        chk("pp_pend_end", 32'(pend_cnt), 32'd0);
        chk("pp_err",      32'(err), 32'd0);

        // ---- unexpected response sets sticky err
        s_rvalid = 1'b1;
        settle();
        chk("ux_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("ux_m1_rvalid", 32'(m1_rvalid), 32'd0);
        cyc();
        s_rvalid = 1'b0;
        settle();
        chk("ux_err", 32'(err), 32'd1);
        cyc();
        settle();
        chk("ux_err_sticky", 32'(err), 32'd1);

        // ---- reset mid-burst with 3 reads pending
        for (int i = 0; i < 3; i++) begin
            m0_read = (i % 2 == 0); m1_read = (i % 2 == 1);
            cyc();
        end
        m1_read = 1'b0; m0_read = 1'b1;
        settle();
        chk("mr_pend3", 32'(pend_cnt), 32'd3);
        sys_rst = 1'b1; s_rvalid = 1'b1;
        settle();
        chk("mr_s_read",    32'(s_read), 32'd0);
        chk("mr_m0_wait",   32'(m0_wait), 32'd1);
        chk("mr_m1_wait",   32'(m1_wait), 32'd1);
        chk("mr_m0_rvalid", 32'(m0_rvalid), 32'd0);
        cyc();
        sys_rst = 1'b0; idle();
        settle();
        chk("mr_pend0",   32'(pend_cnt), 32'd0);
        chk("mr_err0",    32'(err), 32'd0);
        chk("mr_s_read0", 32'(s_read), 32'd0);
        s_rvalid = 1'b1;
        settle();
        chk("mr_late_rvalid", 32'(m0_rvalid), 32'd0);
        cyc();
        s_rvalid = 1'b0;
        settle();
        chk("mr_late_err", 32'(err), 32'd1);

        // ---- read and write together: executed as a write, flags err
        do_reset();
        m0_read = 1'b1; m0_write = 1'b1;
        settle();
        chk("rw_s_write", 32'(s_write), 32'd1);
        chk("rw_s_read",  32'(s_read), 32'd0);
        cyc();
        idle();
        settle();
        chk("rw_err",  32'(err), 32'd1);
        chk("rw_pend", 32'(pend_cnt), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
